// File: rtl/loopback_prbs_checker.sv
// PRBS-7 loopback exerciser: drives a PRBS-7 stream out, finds the
// round-trip latency of the returned bit, then counts bit errors.
module loopback_prbs_checker #(
    parameter int unsigned MAX_LAT  = 15,
    parameter int unsigned LOCK_CNT = 16,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rx_bit,
    output logic             tx_bit,
    output logic             busy,
    output logic             locked,
    output logic             fail,
    output logic [3:0]       latency,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_SEARCH = 3'd2;
    localparam logic [2:0] S_LOCKED = 3'd3;
    localparam logic [2:0] S_FAIL   = 3'd4;

    localparam int unsigned CW = $clog2(LOCK_CNT + 1);
    localparam logic [3:0] LAT_MAX = 4'(MAX_LAT);
    localparam logic [CW-1:0] LOCK_M1 = CW'(LOCK_CNT - 1);

    logic [2:0]    state;
    logic [6:0]    lfsr;
    logic [6:0]    lfsr_nx;
    logic [15:0]   hist;
    logic [3:0]    fill_cnt;
    logic [CW-1:0] match_cnt;
    logic          hit;

    assign lfsr_nx = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    assign hit     = (rx_bit == hist[latency]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            lfsr      <= 7'h7F;
            hist      <= '0;
            tx_bit    <= 1'b0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            latency   <= '0;
            err_count <= '0;
            busy      <= 1'b0;
            locked    <= 1'b0;
            fail      <= 1'b0;
        end else if (start) begin
            // first PRBS bit is lfsr[6] of the reloaded seed, i.e. 1
            state     <= S_FILL;
            lfsr      <= 7'h7F;
            tx_bit    <= 1'b1;
            hist      <= {hist[14:0], 1'b1};
            fill_cnt  <= '0;
            match_cnt <= '0;
            latency   <= '0;
            err_count <= '0;
            busy      <= 1'b1;
            locked    <= 1'b0;
            fail      <= 1'b0;
        end else if (state != S_IDLE) begin
            lfsr   <= lfsr_nx;
            tx_bit <= lfsr_nx[6];
            hist   <= {hist[14:0], lfsr_nx[6]};
            case (state)
                S_FILL: begin
                    if (fill_cnt == LAT_MAX) begin
                        state <= S_SEARCH;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                S_SEARCH: begin
                    if (hit) begin
                        match_cnt <= match_cnt + 1'b1;
                        if (match_cnt == LOCK_M1) begin
                            state  <= S_LOCKED;
                            locked <= 1'b1;
                            busy   <= 1'b0;
                        end
                    end else begin
                        match_cnt <= '0;
                        if (latency == LAT_MAX) begin
                            state <= S_FAIL;
                            fail  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            latency <= latency + 1'b1;
                        end
                    end
                end
                S_LOCKED: begin
                    if (!hit && (err_count != '1)) begin
                        err_count <= err_count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loopback_prbs_checker.sv
// Scoreboard bench for loopback_prbs_checker with a modelled loopback path.
module tb_loopback_prbs_checker;

    localparam int MAX_LAT  = 15;
    localparam int LOCK_CNT = 16;
    localparam int ERR_W    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic rx_bit;
    logic tx_bit;
    logic busy;
    logic locked;
    logic fail;
    logic [3:0] latency;
    logic [ERR_W-1:0] err_count;

    int n_pass = 0;
    int n_total = 0;

    int d = 0;
    logic inv = 1'b0;
    logic tie0 = 1'b0;
    logic [31:0] dl = '0;
    logic prbs [127];

    typedef struct packed {
        logic       busy;
        logic       locked;
        logic       fail;
        logic [3:0] lat;
        logic       chk_tx;
        logic       tx;
    } st_t;

    st_t  st_q[$];
    logic tx_q[$];
    int   err_q[$];
    logic [2:0] st_m = 3'b000;
    int   err_m = 0;

    loopback_prbs_checker #(
        .MAX_LAT(MAX_LAT),
        .LOCK_CNT(LOCK_CNT),
        .ERR_W(ERR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .rx_bit(rx_bit),
        .tx_bit(tx_bit),
        .busy(busy),
        .locked(locked),
        .fail(fail),
        .latency(latency),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // external loopback: delay line on the transmitted bit
    always @(posedge clk) dl <= {dl[30:0], tx_bit};
    assign rx_bit = tie0 ? 1'b0 :
                    (((d == 0) ? tx_bit : dl[5'(d - 1)]) ^ inv);

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic note_fail(input string nm, input int act);
        n_total++;
        $display("FAIL %s: got %0d, expected no change", nm, act);
    endtask

    task automatic push_st(input logic b, input logic l, input logic f,
                           input int lat, input logic ct, input logic t);
        st_t s;
        if ({b, l, f} != st_m) begin
            s = '{busy: b, locked: l, fail: f, lat: 4'(lat),
                  chk_tx: ct, tx: t};
            st_q.push_back(s);
            st_m = {b, l, f};
        end
    endtask

    task automatic set_err(input int v);
        if (v != err_m) begin
            err_q.push_back(v);
            err_m = v;
        end
    endtask

    task automatic start_pulse(input int nd, input logic ntie,
                               input logic push_end);
        bit lock_exp;
        lock_exp = !ntie && (nd <= MAX_LAT);
        @(posedge clk); #1;
        d = nd;
        tie0 = ntie;
        start = 1'b1;
        set_err(0);
        push_st(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        if (push_end) begin
            if (lock_exp) push_st(1'b0, 1'b1, 1'b0, nd, 1'b0, 1'b0);
            else push_st(1'b0, 1'b0, 1'b1, MAX_LAT, 1'b0, 1'b0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 20; k++) tx_q.push_back(prbs[k]);
    endtask

    task automatic run(input int nd, input logic ntie);
        bit lock_exp;
        bit done;
        int bound;
        lock_exp = !ntie && (nd <= MAX_LAT);
        start_pulse(nd, ntie, 1'b1);
        bound = lock_exp ? MAX_LAT + 2 + 7 * nd + LOCK_CNT + 1
                         : MAX_LAT + 2 + 7 * (MAX_LAT + 1) + 3;
        done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (!done) begin
                @(negedge clk);
                if (!busy) done = 1'b1;
            end
        end
        chk($sformatf("done_in_time_d%0d", nd), int'(done), 1);
        chk($sformatf("latency_d%0d", nd), int'(latency),
            lock_exp ? nd : MAX_LAT);
        chk($sformatf("locked_d%0d", nd), int'(locked), int'(lock_exp));
    endtask

    task automatic invert(input int n);
        for (int i = 0; i < n; i++) set_err((err_m < 255) ? err_m + 1 : 255);
        @(posedge clk); #1;
        inv = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        inv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk($sformatf("err_after_invert_%0d", n), int'(err_count), err_m);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx"}, int'(tx_bit), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_fail"}, int'(fail), 0);
        chk({tag, "_latency"}, int'(latency), 0);
        chk({tag, "_err"}, int'(err_count), 0);
    endtask

    // monitor: pops expectations whenever the DUT output changes
    initial begin
        logic [2:0] prev_st;
        int prev_err;
        st_t s;
        logic e;
        int v;
        prev_st = 3'b000;
        prev_err = 0;
        forever begin
            @(negedge clk);
            if (tx_q.size() != 0) begin
                e = tx_q.pop_front();
                chk("tx_bit", int'(tx_bit), int'(e));
            end
            if ({busy, locked, fail} != prev_st) begin
                if (st_q.size() == 0) begin
                    note_fail("status_change", int'({busy, locked, fail}));
                end else begin
                    s = st_q.pop_front();
                    chk("ev_busy", int'(busy), int'(s.busy));
                    chk("ev_locked", int'(locked), int'(s.locked));
                    chk("ev_fail", int'(fail), int'(s.fail));
                    chk("ev_latency", int'(latency), int'(s.lat));
                    if (s.chk_tx) chk("ev_tx", int'(tx_bit), int'(s.tx));
                end
                prev_st = {busy, locked, fail};
            end
            if (int'(err_count) != prev_err) begin
                if (err_q.size() == 0) begin
                    note_fail("err_change", int'(err_count));
                end else begin
                    v = err_q.pop_front();
                    chk("err_count", int'(err_count), v);
                end
                prev_err = int'(err_count);
            end
        end
    end

    initial begin
        logic [6:0] l;
        int nd;
        l = 7'h7F;
        for (int k = 0; k < 127; k++) begin
            prbs[k] = l[6];
            l = {l[5:0], l[6] ^ l[5]};
        end

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("idle");

        run(0, 1'b0);
        run(3, 1'b0);
        run(16, 1'b0);
        run(0, 1'b1);

        run(5, 1'b0);
        invert(2);
        invert(300);
        chk("err_saturated", int'(err_count), 255);

        start_pulse(7, 1'b0, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        push_st(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_all_zero("mid_search_rst");
        run(7, 1'b0);

        run(4, 1'b0);
        invert(10);
        run(9, 1'b0);
        chk("err_cleared", int'(err_count), 0);

        for (int it = 0; it < 4; it++) begin
            nd = int'($urandom_range(0, 17));
            run(nd, 1'b0);
            if (nd <= MAX_LAT) invert(int'($urandom_range(0, 12)));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("tx_q_drained", tx_q.size(), 0);
        chk("st_q_drained", st_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
